// File: rtl/multicycle_control_fsm_if.sv
// Control/handshake bundle between the multicycle control FSM and the
// decoder/datapath/memory side. The FSM is the master: it samples the opcode
// and memory ready, and drives every datapath control.
interface multicycle_control_fsm_if;
  logic [6:0] instruction_opcode;
  logic       mem_ready;

  logic       pc_write_cond;
  logic       pc_write;
  logic       lorD;
  logic       memory_read;
  logic       memory_write;
  logic       memory_to_reg;
  logic       ir_write;
  logic       is_immediate;
  logic       reg_write;
  logic [1:0] pc_source;
  logic [1:0] aluop;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal_instr;
  logic       bus_error;
  logic       halted;
  logic [3:0] state_dbg;

  // Control FSM side
  modport master (
    input  instruction_opcode, mem_ready,
    output pc_write_cond, pc_write, lorD, memory_read, memory_write,
           memory_to_reg, ir_write, is_immediate, reg_write, pc_source,
           aluop, alu_src_a, alu_src_b, illegal_instr, bus_error, halted,
           state_dbg
  );

  // Datapath / memory side
  modport slave (
    output instruction_opcode, mem_ready,
    input  pc_write_cond, pc_write, lorD, memory_read, memory_write,
           memory_to_reg, ir_write, is_immediate, reg_write, pc_source,
           aluop, alu_src_a, alu_src_b, illegal_instr, bus_error, halted,
           state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM with memory ready/wait handshake, bus-timeout
// watchdog, illegal-opcode trap and ECALL/EBREAK halt.
// Optional feature macro: CTRL_PERF_CNT_EN adds cycle_count / instret_count.
// Controls are decoded from the registered state (plus mem_ready for commit
// strobes and bus_error) and are forced low while reset is high.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_W      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_control_fsm_if.master bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [COUNT_W-1:0]     cycle_count,
  output logic [COUNT_W-1:0]     instret_count
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10,
    JALR     = 4'd11,
    AUIPC    = 4'd12,
    LUI      = 4'd13,
    TRAP     = 4'd14,
    HALT     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam bit                   WDOG_EN   = (TIMEOUT_CYCLES != 0);

  // Reject parameter sets the counters cannot represent
  if (TIMEOUT_W == 0 || (64'(TIMEOUT_CYCLES) >> TIMEOUT_W) != 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
  end
  if (COUNT_W == 0) begin : g_bad_count
    $error("COUNT_W must be nonzero");
  end

  state_e               state;
  state_e               state_next;
  state_e               decode_target;
  logic                 opcode_legal;
  logic                 mem_state;
  logic                 timed_out;
  logic [TIMEOUT_W-1:0] wait_cnt;

  // Opcode decoder: dispatch target out of DECODE and legality flag
  always_comb begin
    decode_target = TRAP;
    opcode_legal  = 1'b1;
    case (bus.instruction_opcode)
      OP_LW, OP_SW: decode_target = MEMADR;
      OP_RTYPE:     decode_target = EXECUTER;
      OP_ITYPE:     decode_target = EXECUTEI;
      OP_JAL:       decode_target = JAL;
      OP_BRANCH:    decode_target = BRANCH;
      OP_JALR:      decode_target = JALR;
      OP_AUIPC:     decode_target = AUIPC;
      OP_LUI:       decode_target = LUI;
      OP_SYSTEM:    decode_target = HALT;
      default: begin
        decode_target = TRAP;
        opcode_legal  = 1'b0;
      end
    endcase
  end

  // Watchdog expiry: ready in the same cycle always wins
  always_comb begin
    mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    timed_out = WDOG_EN && mem_state && (wait_cnt == TMO_LIMIT) && !bus.mem_ready;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Wait counter: clears on any state change, saturates at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   wait_cnt <= '0;
    else if (state_next != state)                wait_cnt <= '0;
    else if (mem_state && wait_cnt != TMO_LIMIT) wait_cnt <= wait_cnt + TIMEOUT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (bus.mem_ready)  state_next = DECODE;
        else if (timed_out) state_next = TRAP;
      end
      DECODE:   state_next = decode_target;
      MEMADR:   state_next = (bus.instruction_opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: begin
        if (bus.mem_ready)  state_next = MEMWB;
        else if (timed_out) state_next = TRAP;
      end
      MEMWB:    state_next = FETCH;
      MEMWRITE: begin
        if (bus.mem_ready)  state_next = FETCH;
        else if (timed_out) state_next = TRAP;
      end
      EXECUTER, EXECUTEI, JAL, JALR, AUIPC, LUI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      TRAP:     state_next = FETCH;
      HALT:     state_next = HALT;
      default:  state_next = FETCH;
    endcase
  end

  // Output decode; everything held low during reset
  always_comb begin
    bus.pc_write_cond = 1'b0;
    bus.pc_write      = 1'b0;
    bus.lorD          = 1'b0;
    bus.memory_read   = 1'b0;
    bus.memory_write  = 1'b0;
    bus.memory_to_reg = 1'b0;
    bus.ir_write      = 1'b0;
    bus.is_immediate  = 1'b0;
    bus.reg_write     = 1'b0;
    bus.pc_source     = 2'b00;
    bus.aluop         = 2'b00;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.illegal_instr = 1'b0;
    bus.bus_error     = 1'b0;
    bus.halted        = 1'b0;
    bus.state_dbg     = 4'd0;
    if (!reset) begin
      bus.state_dbg = state;
      bus.bus_error = timed_out;
      case (state)
        FETCH: begin
          bus.memory_read = 1'b1;
          bus.alu_src_b   = 2'b01;
          bus.ir_write    = bus.mem_ready;
          bus.pc_write    = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_b     = 2'b10;
          bus.alu_src_a     = (bus.instruction_opcode == OP_JALR) ? 2'b01 : 2'b00;
          bus.illegal_instr = !opcode_legal;
        end
        MEMADR: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
        end
        MEMREAD: begin
          bus.memory_read = 1'b1;
          bus.lorD        = 1'b1;
        end
        MEMWB: begin
          bus.reg_write     = 1'b1;
          bus.memory_to_reg = 1'b1;
        end
        MEMWRITE: begin
          bus.memory_write = 1'b1;
          bus.lorD         = 1'b1;
        end
        EXECUTER: begin
          bus.alu_src_a = 2'b01;
          bus.aluop     = 2'b10;
        end
        EXECUTEI: begin
          bus.alu_src_a    = 2'b01;
          bus.alu_src_b    = 2'b10;
          bus.aluop        = 2'b10;
          bus.is_immediate = 1'b1;
        end
        JAL, JALR: begin
          bus.alu_src_b    = 2'b01;
          bus.pc_write     = 1'b1;
          bus.pc_source    = 2'b01;
          bus.is_immediate = (state == JALR);
        end
        BRANCH: begin
          bus.alu_src_a     = 2'b01;
          bus.aluop         = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
        end
        AUIPC: bus.alu_src_b = 2'b10;
        LUI: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b10;
        end
        ALUWB: bus.reg_write = 1'b1;
        TRAP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
        HALT: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Performance counters: active cycles and retired instructions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (state != HALT) cycle_count <= cycle_count + COUNT_W'(1);
      if (state_next == FETCH && state != FETCH && state != TRAP)
        instret_count <= instret_count + COUNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Next-generation multicycle RV32I control FSM. Drives the same datapath control signals as the current control unit, and adds:
- a memory ready/wait handshake on every memory-access state;
- a parametrised bus-timeout watchdog;
- illegal-opcode trapping and an ECALL/EBREAK halt state.

Sits between the instruction register/decoder and the multicycle datapath and memory port.

Parameters:
- TIMEOUT_W, 8, width of the memory wait counter.
- TIMEOUT_CYCLES, 255, max wait cycles per memory access before bus error; 0 disables the watchdog.
- COUNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instruction_opcode  in  7  opcode field of the IR
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write_cond, pc_write, lorD, memory_read, memory_write, memory_to_reg, ir_write, is_immediate, reg_write  out  1 each  datapath controls
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 trap vector
- aluop, alu_src_a, alu_src_b  out  2 each  ALU control and operand selects
- illegal_instr  out  1  one-cycle pulse on an undecodable opcode
- bus_error  out  1  one-cycle pulse on memory timeout
- halted  out  1  high while in HALT
- state_dbg  out  4  current state encoding

Behaviour:
- Reset asserted: state = FETCH, wait counter = 0, every output = 0 (outputs forced low while reset is high, including state_dbg = 0). Reset mid-access aborts immediately.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BRANCH 10, JALR 11, AUIPC 12, LUI 13, TRAP 14, HALT 15.
- Opcodes:
  - LW 0000011, SW 0100011 -> MEMADR
  - R-type 0110011 -> EXECUTER
  - I-type 0010011 -> EXECUTEI
  - JAL 1101111 -> JAL
  - branch 1100011 -> BRANCH
  - JALR 1100111 -> JALR
  - AUIPC 0010111 -> AUIPC
  - LUI 0110111 -> LUI
  - SYSTEM 1110011 -> HALT
  - any other opcode -> TRAP, with illegal_instr pulsed during the DECODE cycle
- Memory states (FETCH, MEMREAD, MEMWRITE):
  - memory_read/memory_write and lorD are held for the whole wait.
  - Commit strobes (FETCH: ir_write, pc_write) assert only in the cycle mem_ready = 1.
  - The state advances only on mem_ready = 1; otherwise it stays and the wait counter increments.
- Transitions:
  - MEMADR -> MEMREAD if LW, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH; MEMWRITE -> FETCH.
  - EXECUTER/EXECUTEI/JAL/JALR/AUIPC/LUI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - TRAP -> FETCH.
  - HALT stays in HALT until reset.
- Output decode per state (all other outputs 0):
  - FETCH: memory_read=1, alu_src_b=01, ir_write/pc_write gated by mem_ready.
  - DECODE: alu_src_b=10; alu_src_a=01 if opcode is JALR.
  - MEMADR: alu_src_a=01, alu_src_b=10.
  - MEMREAD: memory_read=1, lorD=1.
  - MEMWB: reg_write=1, memory_to_reg=1.
  - MEMWRITE: memory_write=1, lorD=1.
  - EXECUTER: alu_src_a=01, aluop=10.
  - EXECUTEI: alu_src_a=01, alu_src_b=10, aluop=10, is_immediate=1.
  - JAL: alu_src_b=01, pc_write=1, pc_source=01.
  - JALR: as JAL plus is_immediate=1.
  - BRANCH: alu_src_a=01, aluop=01, pc_write_cond=1, pc_source=01.
  - AUIPC: alu_src_b=10.
  - LUI: alu_src_a=10, alu_src_b=10.
  - ALUWB: reg_write=1.
  - TRAP: pc_write=1, pc_source=10.
  - HALT: halted=1.
- Watchdog:
  - The wait counter clears on every state change and saturates at TIMEOUT_CYCLES.
  - In a memory state, if counter == TIMEOUT_CYCLES and mem_ready = 0: bus_error pulses for 1 cycle, no commit strobe, next state TRAP.
  - mem_ready = 1 in the same cycle as timeout: the access completes normally and no bus_error is raised (ready wins).
- Latency: with mem_ready tied high, LW = 5 cycles, SW = 4, ALU ops/JAL/JALR/AUIPC/LUI = 4, branch = 3.

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined: adds outputs cycle_count[COUNT_W-1:0] and instret_count[COUNT_W-1:0], both reset to 0 and wrapping modulo 2^COUNT_W.
  - cycle_count increments every cycle not in reset or HALT.
  - instret_count increments on every transition into FETCH, except from TRAP.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- mem_ready tied 1, LW opcode -> states 0,1,2,3,4,0; reg_write=memory_to_reg=1 only in cycle 5.
- FETCH with mem_ready low 3 cycles then high -> memory_read high 4 cycles; ir_write/pc_write high only in 4th; state_dbg leaves 0 after 4th.
- TIMEOUT_CYCLES=4, MEMWRITE with mem_ready stuck 0 -> bus_error single pulse after 5 wait cycles; next state 14 with pc_write=1, pc_source=10; then FETCH.
- Opcode 1111111 in DECODE -> illegal_instr pulse; TRAP; then FETCH. Opcode 1110011 -> halted=1 held for 100 cycles; reset -> FETCH.
- Reset asserted asynchronously mid-MEMREAD -> all outputs 0 in same cycle, state_dbg=0; first cycle after release is FETCH.
- With CTRL_PERF_CNT_EN, mem_ready=1, program of 3 R-type ops -> instret_count=3 and cycle_count=12 after 12 cycles.
